// File: rtl/chunked_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : chunked_add_sub
// Description : Multi-cycle two-operand adder. Each RUN cycle resolves CHUNK
//               bits with propagate/generate ripple logic and keeps the carry
//               between chunks in a register. A start/busy/done handshake
//               wraps the computation.
//               Optional feature macro: CHUNKED_SUB_EN (adds port `sub`,
//               which selects a-b instead of a+b+cin).
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CHUNKED_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(NCHUNK - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_partial;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_p;
  logic [CHUNK-1:0] w_g;
  logic [CHUNK:0]   w_c;
  logic [CHUNK-1:0] w_sum_chunk;
  logic [WIDTH-1:0] w_partial_next;
  logic             w_c_out;
  logic             w_c_msb_in;
  logic [WIDTH-1:0] w_b_capture;
  logic             w_carry_capture;

  // Operand conditioning at capture: subtraction is a + ~b + 1
`ifdef CHUNKED_SUB_EN
  assign w_b_capture     = sub ? ~b : b;
  assign w_carry_capture = sub ? 1'b1 : cin;
`else
  assign w_b_capture     = b;
  assign w_carry_capture = cin;
`endif

  // Select the active chunk, ripple its carries and merge it into the partial result
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_a_chunk = r_a[i*CHUNK +: CHUNK];
        w_b_chunk = r_b[i*CHUNK +: CHUNK];
      end
    end
    w_p    = w_a_chunk ^ w_b_chunk;
    w_g    = w_a_chunk & w_b_chunk;
    w_c    = '0;
    w_c[0] = r_carry;
    for (int k = 0; k < CHUNK; k++) begin
      w_c[k+1] = w_g[k] | (w_p[k] & w_c[k]);
    end
    w_sum_chunk    = w_p ^ w_c[CHUNK-1:0];
    w_partial_next = r_partial;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_partial_next[i*CHUNK +: CHUNK] = w_sum_chunk;
      end
    end
  end

  // On the last chunk these are the carries into and out of the result MSB
  assign w_c_out    = w_c[CHUNK];
  assign w_c_msb_in = w_c[CHUNK-1];

  assign busy = (r_state == c_RUN);
  assign done = (r_state == c_DONE);

  // Handshake FSM, chunk sequencing and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      r_partial <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (start) begin
            r_a       <= a;
            r_b       <= w_b_capture;
            r_carry   <= w_carry_capture;
            r_idx     <= '0;
            r_partial <= '0;
            r_state   <= c_RUN;
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_RUN: begin
          r_carry   <= w_c_out;
          r_partial <= w_partial_next;
          if (r_idx == c_LAST_IDX) begin
            sum     <= w_partial_next;
            cout    <= w_c_out;
            ovf     <= w_c_msb_in ^ w_c_out;
            r_idx   <= '0;
            r_state <= c_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
